// File: rtl/rc_microseq_datapath.sv
`default_nettype none
// ============================================================================
// Module   : rc_microseq_datapath
// Purpose  : Register-file datapath with an internal T-state microsequencer.
//            Each accepted instruction runs T0 (Y <= R[ra]), T1 (Z <= ALU,
//            carry update) and T2 (R[rd] <= Z), then pulses done for a cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock    in   system clock, rising edge
//   clear    in   asynchronous active-low reset
//   start    in   instruction request, sampled only in IDLE
//   opcode   in   [2:0] operation, latched with start
//   rd/ra/rb in   [RSEL_W-1:0] destination / source A / source B selects
//   imm      in   [WIDTH-1:0] immediate, latched with start
//   busy     out  high in T0, T1, T2
//   done     out  registered one-cycle completion pulse
//   result   out  [WIDTH-1:0] Z register
//   carry    out  carry/borrow flag from the last ALU op
//   dbg_sel  in   [RSEL_W-1:0] debug read select
//   dbg_data out  [WIDTH-1:0] R[dbg_sel], 0 when dbg_sel >= NREGS
// ============================================================================
module rc_microseq_datapath #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 4,
    parameter int RSEL_W = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [RSEL_W-1:0] rd,
    input  logic [RSEL_W-1:0] ra,
    input  logic [RSEL_W-1:0] rb,
    input  logic [WIDTH-1:0]  imm,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    input  logic [RSEL_W-1:0] dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MV   = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T0   = 2'd1,
        S_T1   = 2'd2,
        S_T2   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q;
    logic [RSEL_W-1:0]  rd_q, ra_q, rb_q;
    logic [WIDTH-1:0]   imm_q;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   y_q, z_q, z_d;
    logic               carry_q, carry_d;
    logic               done_q;

    logic [WIDTH-1:0]   ra_val, rb_val, opb;
    logic [WIDTH:0]     sum, diff;

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_T2);
        end
    end

    // Instruction latch: captured only on the accept edge so operand inputs
    // are free to change while the instruction executes.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            imm_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            op_q  <= opcode;
            rd_q  <= rd;
            ra_q  <= ra;
            rb_q  <= rb;
            imm_q <= imm;
        end
    end

    // ---------------- register file reads ----------------
    // Compare-and-select so out-of-range selects read as zero without
    // indexing past the array.
    always_comb begin
        ra_val   = '0;
        rb_val   = '0;
        dbg_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (ra_q == RSEL_W'(i))    ra_val   = regs_q[i];
            if (rb_q == RSEL_W'(i))    rb_val   = regs_q[i];
            if (dbg_sel == RSEL_W'(i)) dbg_data = regs_q[i];
        end
    end

    // ---------------- ALU ----------------
    always_comb begin
        opb     = (op_q == OP_LDI || op_q == OP_ADDI) ? imm_q : rb_val;
        sum     = {1'b0, y_q} + {1'b0, opb};
        // Top bit of the widened difference is the unsigned borrow.
        diff    = {1'b0, y_q} - {1'b0, opb};
        z_d     = z_q;
        carry_d = carry_q;
        case (op_q)
            OP_NOP:  begin z_d = z_q;            carry_d = carry_q;      end
            OP_LDI:  begin z_d = imm_q;          carry_d = 1'b0;         end
            OP_ADDI: begin z_d = sum[WIDTH-1:0]; carry_d = sum[WIDTH];   end
            OP_ADD:  begin z_d = sum[WIDTH-1:0]; carry_d = sum[WIDTH];   end
            OP_SUB:  begin z_d = diff[WIDTH-1:0]; carry_d = diff[WIDTH]; end
            OP_MV:   begin z_d = y_q;            carry_d = 1'b0;         end
            OP_AND:  begin z_d = y_q & opb;      carry_d = 1'b0;         end
            OP_OR:   begin z_d = y_q | opb;      carry_d = 1'b0;         end
            default: begin z_d = z_q;            carry_d = carry_q;      end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            y_q     <= '0;
            z_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            if (state_q == S_T0) y_q <= ra_val;
            if (state_q == S_T1) begin
                z_q     <= z_d;
                carry_q <= carry_d;
            end
        end
    end

    // Writes to a select with no matching register simply find no target.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (state_q == S_T2 && op_q != OP_NOP) begin
            for (int i = 0; i < NREGS; i++) begin
                if (rd_q == RSEL_W'(i)) regs_q[i] <= z_q;
            end
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = z_q;
    assign carry  = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_rc_microseq_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc_microseq_datapath
// Purpose  : Directed self-checking bench for rc_microseq_datapath, with an
//            8-bit/4-register instance and a 16-bit/8-register instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc_microseq_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit instance
    logic       clear8, start8, busy8, done8, carry8;
    logic [2:0] op8;
    logic [1:0] rd8, ra8, rb8, dsel8;
    logic [7:0] imm8, result8, ddata8;

    // 16-bit instance
    logic        clear16, start16, busy16, done16, carry16;
    logic [2:0]  op16, rd16, ra16, rb16, dsel16;
    logic [15:0] imm16, result16, ddata16;

    rc_microseq_datapath #(.WIDTH(8), .NREGS(4), .RSEL_W(2)) dut8 (
        .clock(clk), .clear(clear8), .start(start8), .opcode(op8),
        .rd(rd8), .ra(ra8), .rb(rb8), .imm(imm8),
        .busy(busy8), .done(done8), .result(result8), .carry(carry8),
        .dbg_sel(dsel8), .dbg_data(ddata8)
    );

    rc_microseq_datapath #(.WIDTH(16), .NREGS(8), .RSEL_W(3)) dut16 (
        .clock(clk), .clear(clear16), .start(start16), .opcode(op16),
        .rd(rd16), .ra(ra16), .rb(rb16), .imm(imm16),
        .busy(busy16), .done(done16), .result(result16), .carry(carry16),
        .dbg_sel(dsel16), .dbg_data(ddata16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input bit w16, input int idx, input logic [31:0] exp);
        if (w16) dsel16 = 3'(idx);
        else     dsel8  = 2'(idx);
        #1;
        chk($sformatf("%s.R%0d", w16 ? "d16" : "d8", idx), w16 ? 32'(ddata16) : 32'(ddata8), exp);
    endtask

    // Issues one instruction and checks busy/done on every cycle up to the
    // cycle after the done pulse.
    task automatic issue(input bit w16, input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm);
        @(negedge clk);
        if (w16) begin
            start16 = 1'b1; op16 = op; rd16 = rd; ra16 = ra; rb16 = rb; imm16 = imm;
        end else begin
            start8 = 1'b1; op8 = op; rd8 = rd[1:0]; ra8 = ra[1:0]; rb8 = rb[1:0]; imm8 = imm[7:0];
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start8 = 1'b0; start16 = 1'b0;
            chk($sformatf("busy.c%0d", c), w16 ? 32'(busy16) : 32'(busy8), 32'(c < 3));
            chk($sformatf("done.c%0d", c), w16 ? 32'(done16) : 32'(done8), 32'(c == 3));
        end
    endtask

    initial begin
        clear8 = 1'b0; start8 = 1'b0; op8 = '0; rd8 = '0; ra8 = '0; rb8 = '0; imm8 = '0; dsel8 = '0;
        clear16 = 1'b0; start16 = 1'b0; op16 = '0; rd16 = '0; ra16 = '0; rb16 = '0; imm16 = '0; dsel16 = '0;
        repeat (2) @(negedge clk);
        clear8 = 1'b1; clear16 = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst.busy", 32'(busy8), 0);
        chk("rst.done", 32'(done8), 0);
        chk("rst.result", 32'(result8), 0);
        chk("rst.carry", 32'(carry8), 0);
        for (int i = 0; i < 4; i++) chk_reg(1'b0, i, 0);
        chk_reg(1'b1, 7, 0);

        // LDI R0,5 ; ADDI R1,R0,5
        issue(1'b0, 3'b001, 3'd0, 3'd0, 3'd0, 16'h0005);
        chk_reg(1'b0, 0, 8'h05);
        chk("ldi.result", 32'(result8), 8'h05);
        issue(1'b0, 3'b010, 3'd1, 3'd0, 3'd0, 16'h0005);
        chk_reg(1'b0, 1, 8'h0A);
        chk("addi.carry", 32'(carry8), 0);

        // R2=F0, R3=20 ; ADD R2,R2,R3 ; SUB R3,R2,R3
        issue(1'b0, 3'b001, 3'd2, 3'd0, 3'd0, 16'h00F0);
        issue(1'b0, 3'b001, 3'd3, 3'd0, 3'd0, 16'h0020);
        chk("ldi.carry", 32'(carry8), 0);
        issue(1'b0, 3'b011, 3'd2, 3'd2, 3'd3, 16'h0000);
        chk_reg(1'b0, 2, 8'h10);
        chk("add.carry", 32'(carry8), 1);
        issue(1'b0, 3'b100, 3'd3, 3'd2, 3'd3, 16'h0000);
        chk_reg(1'b0, 3, 8'hF0);
        chk("sub.carry", 32'(carry8), 1);

        // AND R0,R2,R3 = 10&F0 ; OR R1,R0,R3 = 10|F0 ; MV R0,R3
        issue(1'b0, 3'b110, 3'd0, 3'd2, 3'd3, 16'h0000);
        chk_reg(1'b0, 0, 8'h10);
        chk("and.carry", 32'(carry8), 0);
        issue(1'b0, 3'b111, 3'd1, 3'd0, 3'd3, 16'h0000);
        chk_reg(1'b0, 1, 8'hF0);
        issue(1'b0, 3'b101, 3'd0, 3'd3, 3'd0, 16'h0055);
        chk_reg(1'b0, 0, 8'hF0);
        chk("mv.result", 32'(result8), 8'hF0);

        // start held high 12 cycles: ADDI R0,R0,1 accepted at k, k+4, k+8
        @(negedge clk);
        start8 = 1'b1; op8 = 3'b010; rd8 = 2'd0; ra8 = 2'd0; rb8 = 2'd0; imm8 = 8'h01;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 11) start8 = 1'b0;
            chk($sformatf("hold.busy.c%0d", c), 32'(busy8), 32'(c < 12 && (c % 4) != 3));
            chk($sformatf("hold.done.c%0d", c), 32'(done8), 32'(c < 12 && (c % 4) == 3));
        end
        chk_reg(1'b0, 0, 8'hF3);

        // clear during T1 of ADDI R1,R0,1
        @(negedge clk);
        start8 = 1'b1; op8 = 3'b010; rd8 = 2'd1; ra8 = 2'd0; imm8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);                      // now in T1
        clear8 = 1'b0;
        #1;
        chk("clr.busy", 32'(busy8), 0);
        chk("clr.done", 32'(done8), 0);
        chk("clr.result", 32'(result8), 0);
        @(negedge clk);
        clear8 = 1'b1;
        repeat (4) @(negedge clk);
        chk("clr.done_after", 32'(done8), 0);
        chk_reg(1'b0, 1, 8'h00);
        issue(1'b0, 3'b001, 3'd1, 3'd0, 3'd0, 16'h0033);
        chk_reg(1'b0, 1, 8'h33);

        // 16-bit instance: LDI R7,FFFF ; ADDI R7,R7,1 ; NOP
        issue(1'b1, 3'b001, 3'd7, 3'd0, 3'd0, 16'hFFFF);
        chk_reg(1'b1, 7, 16'hFFFF);
        issue(1'b1, 3'b010, 3'd7, 3'd7, 3'd0, 16'h0001);
        chk_reg(1'b1, 7, 16'h0000);
        chk("d16.addi.carry", 32'(carry16), 1);
        chk("d16.addi.result", 32'(result16), 0);
        issue(1'b1, 3'b000, 3'd5, 3'd7, 3'd7, 16'h1234);
        chk_reg(1'b1, 5, 16'h0000);
        chk_reg(1'b1, 7, 16'h0000);
        chk("d16.nop.carry", 32'(carry16), 1);
        chk("d16.nop.result", 32'(result16), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc_microseq_datapath.md
Name: rc_microseq_datapath

Overview:
Parametrised register-file datapath with an internal T-state microsequencer. Each accepted instruction runs the fixed T0/T1/T2 sequence itself: operand fetch into Y, ALU result into Z, writeback to Rd. Testbenches no longer drive per-step register in/out strobes. It replaces the fixed three-register (A/B/Z) datapath and issues one instruction per start/done handshake.

Parameters:
WIDTH, 8, data width of registers, bus, immediate, Z and ALU.
NREGS, 4, number of general registers R0..R(NREGS-1).
RSEL_W, 2, register-select width; must satisfy 2**RSEL_W >= NREGS.

Ports:
clock  in  1  system clock; all state updates on rising edge.
clear  in  1  asynchronous, active-low reset.
start  in  1  instruction request; sampled only in IDLE.
opcode  in  3  operation, latched with start.
rd  in  RSEL_W  destination register, latched with start.
ra  in  RSEL_W  source A, latched with start.
rb  in  RSEL_W  source B, latched with start.
imm  in  WIDTH  immediate, latched with start.
busy  out  1  high while state is T0, T1 or T2.
done  out  1  one-cycle completion pulse, registered.
result  out  WIDTH  current Z register contents.
carry  out  1  carry/borrow flag from the last ALU op.
dbg_sel  in  RSEL_W  debug read select.
dbg_data  out  WIDTH  combinational read of R[dbg_sel]; 0 if dbg_sel >= NREGS.

Behaviour:
- Reset (clear=0, asynchronous):
  - all R[i], Y, Z, carry cleared to 0; busy=0, done=0; state=IDLE; latched instruction cleared.
  - Asserting reset mid-instruction abandons the instruction with no writeback; the first post-reset cycle is IDLE.
- States: IDLE -> T0 -> T1 -> T2 -> IDLE. No other transitions.
- IDLE:
  - If start=1 at a rising edge: latch opcode/rd/ra/rb/imm and go to T0.
  - Otherwise stay in IDLE.
- T0: Y <= R[ra].
- T1: Z <= ALU(Y, operand B). Operand B is imm for LDI/ADDI and R[rb] otherwise. Carry is updated here.
- T2: R[rd] <= Z, except for NOP. Next state is IDLE, with done registered to 1 for exactly one cycle.
- Latency:
  - start sampled at edge k; writeback at edge k+3.
  - done high during cycle k+3..k+4.
  - Earliest next start accepted at edge k+4 (4-cycle issue interval). start is allowed while done=1.
- start while busy=1 is ignored: not queued, no effect.
- Opcodes:
  - 000 NOP: no writeback; Z and carry unchanged; still completes with done.
  - 001 LDI: Z = imm; carry = 0.
  - 010 ADDI: Z = Y + imm; carry = carry-out.
  - 011 ADD: Z = Y + R[rb]; carry = carry-out.
  - 100 SUB: Z = Y - R[rb]; carry = 1 iff Y < R[rb] (unsigned borrow).
  - 101 MV: Z = Y; carry = 0.
  - 110 AND: Z = Y & R[rb]; carry = 0.
  - 111 OR: Z = Y | R[rb]; carry = 0.
- All arithmetic is unsigned, modulo 2**WIDTH.
- Sources are read in T0 and T1, so rd == ra or rd == rb is legal. Sources see values from before this instruction's writeback.
- Select index >= NREGS:
  - reads return 0;
  - writes are dropped, but done still pulses.
- result follows Z at all times; it is not masked by busy.
- dbg_data reflects a writeback in the cycle following the writeback edge.
- Opcode and operand inputs are don't-care except at the start-accept edge.

Test Plan:
- Reset then dbg_sel sweep 0..3 -> all dbg_data=0; busy=0, done=0, result=0, carry=0.
- LDI rd=0 imm=5, then ADDI rd=1 ra=0 imm=5, then MV rd=1... (sequence: LDI R0,5; ADDI Z=R0+5; writeback R1) -> R0=5, R1=10 (0x0A); each done exactly 3 edges after accept; busy high for 3 cycles.
- R2=0xF0, R3=0x20; ADD rd=2 ra=2 rb=3 -> R2=0x10, carry=1. Then SUB rd=3 ra=2 rb=3 -> R3=0xF0, carry=1.
- start held high continuously for 12 cycles -> exactly 3 instructions accepted, at edges k, k+4, k+8; start during busy is ignored.
- clear pulsed low during T1 of ADDI rd=1 -> R1 stays 0; busy and done drop immediately; a later instruction runs normally.
- WIDTH=16, NREGS=8, RSEL_W=3: LDI R7,0xFFFF then ADDI R7,R7,1 -> R7=0x0000, carry=1. NOP -> registers, Z and carry unchanged; done pulses once.
